// File: rtl/phy_rx_pkg.sv
// Shared symbols, lane FSM encoding and word-geometry helper for the multilane PHY receiver.
package phy_rx_pkg;

    localparam logic [7:0] COM_DEF  = 8'hBC;
    localparam logic [7:0] IDLE_DEF = 8'h7C;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } lane_state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/phy_rx_lane.sv
// One serial lane: COM byte alignment, lock qualification and byte delivery to the assembler.
module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM       = COM_DEF,
    parameter logic [7:0] IDLE      = IDLE_DEF,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       i_bit,
    input  logic       i_clr,
    output logic [7:0] o_byte,
    output logic       o_is_data,
    output logic       o_byte_rdy,
    output logic       o_active
);

    localparam int CNT_W = $clog2(COM_COUNT + 1);

    lane_state_t      r_state, w_state_nxt;
    logic [7:0]       r_sr, w_sr_nxt;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_com_cnt, w_com_cnt_nxt, w_com_inc;
    logic             w_wrap, w_is_com, w_realign, w_emit;

    // The byte completes on the edge that samples its 8th bit, so decode the post-shift value.
    assign w_sr_nxt  = {r_sr[6:0], i_bit};
    assign w_wrap    = (r_bit_cnt == 3'd7);
    assign w_is_com  = (w_sr_nxt == COM);
    assign w_com_inc = r_com_cnt + CNT_W'(1);
    assign o_active  = (r_state == ST_ACTIVE);

    always_comb begin
        w_state_nxt   = r_state;
        w_com_cnt_nxt = r_com_cnt;
        w_realign     = 1'b0;
        w_emit        = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_is_com) begin
                    w_realign     = 1'b1;
                    w_com_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = (COM_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_wrap) begin
                    if (w_is_com) begin
                        w_com_cnt_nxt = w_com_inc;
                        if (w_com_inc == CNT_W'(COM_COUNT)) w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_com_cnt_nxt = '0;
                        w_state_nxt   = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: w_emit = w_wrap;
            default:   w_state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state    <= ST_SEARCH;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_com_cnt  <= '0;
            o_byte     <= '0;
            o_is_data  <= 1'b0;
            o_byte_rdy <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_bit_cnt <= w_realign ? 3'd0 : r_bit_cnt + 3'd1;
            // A fresh byte wins over the assembler's clear when a 7-bit skew makes them coincide.
            if (w_emit) begin
                o_byte     <= w_sr_nxt;
                o_is_data  <= (w_sr_nxt != IDLE) && (w_sr_nxt != COM);
                o_byte_rdy <= 1'b1;
            end else if (i_clr) begin
                o_byte_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/phy_rx_multilane.sv
// Multilane receiver top: per-lane aligners plus the byte-striped word assembler.
module phy_rx_multilane
    import phy_rx_pkg::*;
#(
    parameter int         LANES     = 2,
    parameter int         DATA_W    = 32,
    parameter logic [7:0] COM       = COM_DEF,
    parameter logic [7:0] IDLE      = IDLE_DEF,
    parameter int         COM_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [LANES-1:0]  data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [LANES-1:0]  active,
    output logic              err_out
);

    localparam int                SLOTS     = bytes_per_word(DATA_W) / LANES;
    localparam int                SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic [7:0]        w_byte [LANES];
    logic [LANES-1:0]  w_is_data, w_byte_rdy;
    logic              w_fire, w_all_data, w_no_data, w_last;
    logic [DATA_W-1:0] w_fill;
    logic [SLOT_W-1:0] r_slot;
    logic [DATA_W-1:0] r_acc, r_word_p0;
    logic              r_vld_p0, r_err_p0;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            phy_rx_lane #(
                .COM       (COM),
                .IDLE      (IDLE),
                .COM_COUNT (COM_COUNT)
            ) u_lane (
                .clk_32f    (clk_32f),
                .reset      (reset),
                .i_bit      (data_in[gi]),
                .i_clr      (w_fire),
                .o_byte     (w_byte[gi]),
                .o_is_data  (w_is_data[gi]),
                .o_byte_rdy (w_byte_rdy[gi]),
                .o_active   (active[gi])
            );
        end
    endgenerate

    assign w_fire     = (&w_byte_rdy) & (&active);
    assign w_all_data = &w_is_data;
    assign w_no_data  = ~|w_is_data;
    assign w_last     = (r_slot == LAST_SLOT);

    always_comb begin
        w_fill = r_acc;
        for (int s = 0; s < SLOTS; s++) begin
            if (r_slot == SLOT_W'(s)) begin
                for (int i = 0; i < LANES; i++)
                    w_fill[DATA_W-1-8*(s*LANES+i) -: 8] = w_byte[i];
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_slot    <= '0;
            r_acc     <= '0;
            r_word_p0 <= '0;
            r_vld_p0  <= 1'b0;
            r_err_p0  <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            // p0: consume one slot of lane bytes
            r_vld_p0 <= 1'b0;
            r_err_p0 <= 1'b0;
            if (w_fire) begin
                if (w_all_data) begin
                    r_acc <= w_fill;
                    if (w_last) begin
                        r_word_p0 <= w_fill;
                        r_vld_p0  <= 1'b1;
                        r_slot    <= '0;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end else begin
                    // Filler-only slots are harmless unless they interrupt a partial word.
                    r_err_p0 <= !w_no_data || (r_slot != '0);
                    r_slot   <= '0;
                end
            end
            // p1: publish the completed word or the discard pulse
            valid_out <= r_vld_p0;
            err_out   <= r_err_p0;
            if (r_vld_p0) data_out <= r_word_p0;
        end
    end

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Randomised scenarios on 2-lane and 4-lane receivers, checked cycle by cycle against a byte-stream model.
module tb_phy_rx_multilane;

    localparam int         CC   = 4;
    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam int         MAXT = 256;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [1:0]  din2, act2;
    logic [3:0]  din4, act4;
    logic [31:0] dout2, dout4;
    logic        vld2, vld4, err2, err4;

    always #5 clk_32f = ~clk_32f;

    phy_rx_multilane #(.LANES(2), .DATA_W(32), .COM(COM), .IDLE(IDLE), .COM_COUNT(CC)) dut2 (
        .clk_32f(clk_32f), .reset(reset), .data_in(din2), .data_out(dout2),
        .valid_out(vld2), .active(act2), .err_out(err2));

    phy_rx_multilane #(.LANES(4), .DATA_W(32), .COM(COM), .IDLE(IDLE), .COM_COUNT(CC)) dut4 (
        .clk_32f(clk_32f), .reset(reset), .data_in(din4), .data_out(dout4),
        .valid_out(vld4), .active(act4), .err_out(err4));

    int n_checks = 0;
    int n_pass   = 0;

    // Scenario description: selected DUT (lane count), per-lane skew, leading COMs, payload slots.
    int         sel, ncom, nslots, T, cyc;
    logic       chk_en;
    int         skew [4];
    logic [7:0] pay [4][32];

    logic [3:0]  exp_act  [MAXT];
    logic        exp_vld  [MAXT];
    logic        exp_err  [MAXT];
    logic [31:0] exp_dout [MAXT];

    int          obs_vld_cnt, obs_vld_edge, obs_err_cnt, obs_err_edge, obs_act_first;
    logic [31:0] obs_word;
    logic [3:0]  obs_act_any;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, want);
    endtask

    function automatic logic [7:0] lane_byte(input int lane, input int idx);
        if (idx < ncom) return COM;
        if (ncom < CC) return 8'h00;
        if (idx - CC < nslots) return pay[lane][idx-CC];
        return IDLE;
    endfunction

    function automatic logic lane_bit(input int lane, input int t);
        logic [7:0] b;
        int off;
        if (t < skew[lane]) return 1'b0;
        off = t - skew[lane];
        b = lane_byte(lane, off / 8);
        return b[7 - (off % 8)];
    endfunction

    function automatic bit is_data(input logic [7:0] b);
        return (b != IDLE) && (b != COM);
    endfunction

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        do b = 8'($urandom); while (!is_data(b));
        return b;
    endfunction

    // Expected outputs per cycle: each lane locks after CC COMs, slot k is stream byte CC+k of
    // every lane, and its outcome appears two edges after the latest lane's final bit.
    task automatic build_model();
        int pos, nd, L, v;
        logic [31:0] word;
        pos  = 0;
        word = '0;
        for (int t = 0; t < MAXT; t++) begin
            exp_act[t] = '0; exp_vld[t] = 1'b0; exp_err[t] = 1'b0; exp_dout[t] = '0;
        end
        if (ncom >= CC)
            for (int t = 0; t < T; t++)
                for (int i = 0; i < sel; i++)
                    if (t >= skew[i] + 8*CC - 1) exp_act[t][i] = 1'b1;
        for (int k = 0; ncom >= CC; k++) begin
            L = 0;
            for (int i = 0; i < sel; i++) begin
                v = skew[i] + 8*(CC+k) + 7;
                if (v > L) L = v;
            end
            if (L + 2 >= T) break;
            nd = 0;
            for (int i = 0; i < sel; i++) if (is_data(lane_byte(i, CC+k))) nd++;
            if (nd == sel) begin
                for (int i = 0; i < sel; i++) word[31-8*(pos*sel+i) -: 8] = lane_byte(i, CC+k);
                pos++;
                if (pos * sel == 4) begin
                    exp_vld[L+2] = 1'b1;
                    for (int t = L + 2; t < T; t++) exp_dout[t] = word;
                    pos = 0;
                end
            end else begin
                if (nd != 0 || pos > 0) exp_err[L+2] = 1'b1;
                pos = 0;
            end
        end
    endtask

    task automatic check_dut(input string tag, input logic [3:0] a, input logic v, input logic e,
                             input logic [31:0] d, input logic [3:0] ea, input logic ev,
                             input logic ee, input logic [31:0] ed);
        chk({tag, "_active"},   {28'b0, a}, {28'b0, ea});
        chk({tag, "_valid"},    {31'b0, v}, {31'b0, ev});
        chk({tag, "_err"},      {31'b0, e}, {31'b0, ee});
        chk({tag, "_data_out"}, d, ed);
    endtask

    task automatic observe(input logic [3:0] a, input logic v, input logic e,
                           input logic [31:0] d, input logic [3:0] full);
        if (v) begin obs_vld_cnt++; obs_vld_edge = cyc; obs_word = d; end
        if (e) begin obs_err_cnt++; obs_err_edge = cyc; end
        obs_act_any = obs_act_any | a;
        if (obs_act_first < 0 && a == full) obs_act_first = cyc;
    endtask

    always begin : compare
        @(posedge clk_32f);
        #1;
        if (chk_en) begin
            if (sel == 2) begin
                check_dut("dut2", {2'b0, act2}, vld2, err2, dout2,
                          exp_act[cyc], exp_vld[cyc], exp_err[cyc], exp_dout[cyc]);
                check_dut("dut4", act4, vld4, err4, dout4, 4'h0, 1'b0, 1'b0, 32'h0);
                observe({2'b0, act2}, vld2, err2, dout2, 4'h3);
            end else begin
                check_dut("dut4", act4, vld4, err4, dout4,
                          exp_act[cyc], exp_vld[cyc], exp_err[cyc], exp_dout[cyc]);
                check_dut("dut2", {2'b0, act2}, vld2, err2, dout2, 4'h0, 1'b0, 1'b0, 32'h0);
                observe(act4, vld4, err4, dout4, 4'hF);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_32f);
        reset  = 1'b1;
        din2   = '0;
        din4   = '0;
        chk_en = 1'b0;
        @(posedge clk_32f);
        #1;
        chk("rst_active2", {30'b0, act2}, 32'h0);
        chk("rst_active4", {28'b0, act4}, 32'h0);
        chk("rst_valid",   {30'b0, vld2, vld4}, 32'h0);
        chk("rst_err",     {30'b0, err2, err4}, 32'h0);
        chk("rst_dout2",   dout2, 32'h0);
        chk("rst_dout4",   dout4, 32'h0);
        repeat (4) @(posedge clk_32f);
    endtask

    task automatic run_sc();
        build_model();
        obs_vld_cnt = 0; obs_vld_edge = -1; obs_err_cnt = 0; obs_err_edge = -1;
        obs_act_first = -1; obs_act_any = '0; obs_word = '0;
        for (int t = 0; t < T; t++) begin
            @(negedge clk_32f);
            reset  = 1'b0;
            cyc    = t;
            chk_en = 1'b1;
            for (int i = 0; i < 2; i++) din2[i] = (sel == 2) ? lane_bit(i, t) : 1'b0;
            for (int i = 0; i < 4; i++) din4[i] = (sel == 4) ? lane_bit(i, t) : 1'b0;
        end
        @(negedge clk_32f);
        chk_en = 1'b0;
    endtask

    task automatic set_skew(input int s0, input int s1, input int s2, input int s3);
        skew[0] = s0; skew[1] = s1; skew[2] = s2; skew[3] = s3;
    endtask

    initial begin
        int r, j;
        reset  = 1'b1;
        din2   = '0;
        din4   = '0;
        chk_en = 1'b0;
        cyc    = 0;

        // Idle lanes never lock.
        do_reset();
        sel = 2; ncom = 0; nslots = 0; T = 80; set_skew(0, 0, 0, 0);
        run_sc();
        chk("idle_active_any", {28'b0, obs_act_any}, 32'h0);
        chk("idle_valid_cnt", obs_vld_cnt, 32'd0);

        // Three COMs are one short of lock.
        do_reset();
        sel = 2; ncom = 3; nslots = 0; T = 64;
        run_sc();
        chk("com3_active_any", {28'b0, obs_act_any}, 32'h0);

        // Aligned lanes, DE BE / AD EF.
        do_reset();
        sel = 2; ncom = CC; nslots = 2; T = 60; set_skew(0, 0, 0, 0);
        pay[0][0] = 8'hDE; pay[0][1] = 8'hBE; pay[1][0] = 8'hAD; pay[1][1] = 8'hEF;
        run_sc();
        chk("aligned_active_edge", obs_act_first, 32'd31);
        chk("aligned_valid_cnt", obs_vld_cnt, 32'd1);
        chk("aligned_valid_edge", obs_vld_edge, 32'd49);
        chk("aligned_word", obs_word, 32'hDEADBEEF);

        // Lane 1 five bits late.
        do_reset();
        set_skew(0, 5, 0, 0); T = 66;
        run_sc();
        chk("skew5_active_edge", obs_act_first, 32'd36);
        chk("skew5_valid_edge", obs_vld_edge, 32'd54);
        chk("skew5_word", obs_word, 32'hDEADBEEF);

        // Data slot then filler slot discards the word; next word survives.
        do_reset();
        set_skew(0, 0, 0, 0); nslots = 4; T = 72;
        pay[0][0] = 8'hDE; pay[0][1] = IDLE; pay[0][2] = 8'h12; pay[0][3] = 8'h56;
        pay[1][0] = 8'hAD; pay[1][1] = IDLE; pay[1][2] = 8'h34; pay[1][3] = 8'h78;
        run_sc();
        chk("discard_err_cnt", obs_err_cnt, 32'd1);
        chk("discard_err_edge", obs_err_edge, 32'd49);
        chk("discard_valid_cnt", obs_vld_cnt, 32'd1);
        chk("discard_valid_edge", obs_vld_edge, 32'd65);
        chk("discard_word", obs_word, 32'h12345678);

        // Four lanes, one word per byte period, run stops mid-byte before the next reset.
        do_reset();
        sel = 4; ncom = CC; nslots = 3; T = 70; set_skew(0, 3, 7, 1);
        for (int k = 0; k < 3; k++) begin
            pay[0][k] = 8'hDE; pay[1][k] = 8'hAD; pay[2][k] = 8'hBE; pay[3][k] = 8'hEF;
        end
        run_sc();
        chk("quad_valid_cnt", obs_vld_cnt, 32'd3);
        chk("quad_word", obs_word, 32'hDEADBEEF);

        // Randomised scenarios.
        for (int n = 0; n < 24; n++) begin
            do_reset();
            sel    = ($urandom_range(0, 1) == 1) ? 4 : 2;
            ncom   = CC;
            nslots = $urandom_range(2, 10);
            set_skew($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            for (int k = 0; k < nslots; k++) begin
                r = $urandom_range(0, 9);
                j = $urandom_range(0, sel - 1);
                for (int i = 0; i < 4; i++) begin
                    if (r < 6)                 pay[i][k] = rand_data();
                    else if (r < 8 || i == j)  pay[i][k] = ($urandom_range(0, 1) == 1) ? IDLE : COM;
                    else                       pay[i][k] = rand_data();
                end
            end
            T = 7 + 8*(CC + nslots) + $urandom_range(0, 20);
            run_sc();
        end

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
